cpu7_ifu_fetch_queue: RTL

Parametrised fetch front end: generates line-aligned fetch requests and buffers the returned 128-bit lines in a circular instruction queue. It presents up to NPORT in-order instructions per cycle to decode and handles redirects with in-flight response discard. It sits between the instruction cache interface and decode stage 1, replacing the single-port, unbuffered fetch datapath.

---
 rtl/cpu7_ifu_pkg.sv | 20 ++
 rtl/cpu7_ifu_fq_ptr.sv | 48 ++++
 rtl/cpu7_ifu_fetch_queue.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_ifu_pkg.sv
// Shared types for the cpu7 instruction fetch unit: queue entry layout and
// fetch FSM states.
package cpu7_ifu_pkg;

    localparam int LINE_WORDS = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [5:0]  exccode;
    } fq_entry_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fq_state_e;

endpackage

// File: rtl/cpu7_ifu_fq_ptr.sv
// Head/tail/occupancy bookkeeping for the circular fetch queue; a flush
// empties the queue by pulling head up to tail.
module cpu7_ifu_fq_ptr #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_i,
    input  logic [2:0]    push_cnt_i,
    input  logic [2:0]    pop_cnt_i,
    output logic [AW-1:0] head_o,
    output logic [AW-1:0] tail_o,
    output logic [AW:0]   occ_o
);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   occ_q, occ_d;

    always_comb begin
        head_d = head_q + AW'(pop_cnt_i);
        tail_d = tail_q + AW'(push_cnt_i);
        occ_d  = occ_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_cnt_i);
        if (flush_i) begin
            head_d = tail_q;
            tail_d = tail_q;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = head_q;
    assign tail_o = tail_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/cpu7_ifu_fetch_queue.sv
// Fetch front end: line-aligned requests, circular instruction queue, NPORT
// in-order decode ports. Define CPU7_IFU_FQ_PERF_EN to add perf counters.
module cpu7_ifu_fetch_queue
    import cpu7_ifu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int NPORT     = 3,
    parameter int MAX_OUTST = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         pc_init,
    output logic                inst_req,
    output logic [31:0]         inst_addr,
    input  logic                inst_addr_ok,
    input  logic                inst_valid,
    input  logic [127:0]        inst_rdata,
    input  logic                inst_ex,
    input  logic [5:0]          inst_exccode,
    output logic                inst_cancel,
    input  logic                br_cancel,
    input  logic [31:0]         br_target,
    input  logic [NPORT-1:0]    o_allow,
    output logic [NPORT-1:0]    o_valid,
    output logic [NPORT*32-1:0] o_port_pc,
    output logic [NPORT*32-1:0] o_port_inst,
    output logic [NPORT-1:0]    o_port_ex,
    output logic [NPORT*6-1:0]  o_port_exccode,
    output logic [NPORT-1:0]    o_port_taken
`ifdef CPU7_IFU_FQ_PERF_EN
    ,
    output logic [31:0]         perf_fetch_lines,
    output logic [31:0]         perf_stall_full,
    output logic [31:0]         perf_discard
`endif
);

    localparam int AW = $clog2(DEPTH);

    fq_state_e     state_q;
    logic [31:2]   fetch_pc_q;
    logic [1:0]    outst_q, outst_d;
    logic [1:0]    discard_q, discard_d;
    logic [29:0]   ofifo_q [MAX_OUTST];
    logic [29:0]   ofifo_d [MAX_OUTST];
    logic [1:0]    ocnt_q, ocnt_d;
    logic          inst_cancel_q;
    fq_entry_t     mem_q [DEPTH];

    logic [AW-1:0] head, tail;
    logic [AW:0]   occ;
    logic [31:0]   free_words, need_words;
    logic          space_ok, accept, drop, keep;
    logic [29:0]   req_word;
    logic [1:0]    req_off, wsel;
    logic [2:0]    push_cnt, pop_cnt;
    logic          pop_run;
    logic [LINE_WORDS-1:0] wr_en;
    logic [AW-1:0] wr_idx [LINE_WORDS];
    fq_entry_t     wr_data [LINE_WORDS];
    fq_entry_t     port_e;
    logic          unused_ok;

    // Room is reserved for a full line per in-flight request, so responses never overflow.
    assign free_words = 32'(DEPTH) - 32'(occ);
    assign need_words = (32'(outst_q) + 32'd1) << 2;
    assign space_ok   = free_words >= need_words;
    assign inst_req   = (state_q == RUN) && (32'(outst_q) < 32'(MAX_OUTST)) && space_ok;
    assign inst_addr  = {fetch_pc_q, 2'b00};
    assign accept     = inst_req & inst_addr_ok;
    assign drop       = inst_valid & (br_cancel | (discard_q != 2'd0));
    assign keep       = inst_valid & ~drop;
    assign req_word   = ofifo_q[0];
    assign req_off    = req_word[1:0];
    assign inst_cancel  = inst_cancel_q;
    assign o_port_taken = '0;
    assign unused_ok  = ^{pc_init[1:0], br_target[1:0]};

    always_comb begin
        push_cnt = 3'd0;
        if (keep) push_cnt = inst_ex ? 3'd1 : 3'(LINE_WORDS) - {1'b0, req_off};
    end

    always_comb begin
        pop_cnt = 3'd0;
        pop_run = 1'b1;
        for (int i = 0; i < NPORT; i++) begin
            if (pop_run && (occ > (AW+1)'(i)) && o_allow[i]) pop_cnt = pop_cnt + 3'd1;
            else pop_run = 1'b0;
        end
    end

    cpu7_ifu_fq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (br_cancel),
        .push_cnt_i (push_cnt),
        .pop_cnt_i  (pop_cnt),
        .head_o     (head),
        .tail_o     (tail),
        .occ_o      (occ)
    );

    // Every response retires one outstanding request, kept or dropped.
    always_comb begin
        outst_d   = outst_q + {1'b0, accept} - {1'b0, inst_valid};
        discard_d = discard_q;
        if (br_cancel) discard_d = outst_d;
        else if (inst_valid && discard_q != 2'd0) discard_d = discard_q - 2'd1;
    end

    always_comb begin
        for (int i = 0; i < MAX_OUTST; i++) ofifo_d[i] = ofifo_q[i];
        if (keep) begin
            for (int i = 0; i < MAX_OUTST - 1; i++) ofifo_d[i] = ofifo_q[i+1];
        end
        if (accept) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (2'(i) == ocnt_q - {1'b0, keep}) ofifo_d[i] = fetch_pc_q;
            end
        end
        ocnt_d = br_cancel ? 2'd0 : ocnt_q + {1'b0, accept} - {1'b0, keep};
    end

    always_ff @(posedge clock) begin
        ofifo_q <= ofifo_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= INIT;
            fetch_pc_q    <= '0;
            outst_q       <= '0;
            discard_q     <= '0;
            ocnt_q        <= '0;
            inst_cancel_q <= 1'b0;
        end else begin
            outst_q       <= outst_d;
            discard_q     <= discard_d;
            ocnt_q        <= ocnt_d;
            inst_cancel_q <= br_cancel;
            case (state_q)
                INIT: begin
                    state_q    <= RUN;
                    fetch_pc_q <= pc_init[31:2];
                end
                default: begin
                    if (br_cancel) begin
                        state_q    <= RUN;
                        fetch_pc_q <= br_target[31:2];
                    end else begin
                        if (accept) fetch_pc_q <= {fetch_pc_q[31:4] + 28'd1, 2'b00};
                        if (keep && inst_ex) state_q <= HALT;
                    end
                end
            endcase
        end
    end

    // An exception response becomes a single marker entry at the requested PC.
    always_comb begin
        wsel = '0;
        for (int j = 0; j < LINE_WORDS; j++) begin
            wsel       = req_off + 2'(j);
            wr_en[j]   = 3'(j) < push_cnt;
            wr_idx[j]  = tail + AW'(j);
            wr_data[j] = inst_ex ? {req_word, 2'b00, 32'd0, 1'b1, inst_exccode}
                                 : {req_word[29:2], wsel, 2'b00,
                                    inst_rdata[{wsel, 5'b00000} +: 32], 1'b0, 6'd0};
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < LINE_WORDS; j++) begin
            if (wr_en[j]) mem_q[wr_idx[j]] <= wr_data[j];
        end
    end

    always_comb begin
        port_e = '0;
        for (int i = 0; i < NPORT; i++) begin
            port_e                   = mem_q[head + AW'(i)];
            o_valid[i]               = occ > (AW+1)'(i);
            o_port_pc[32*i +: 32]    = port_e.pc;
            o_port_inst[32*i +: 32]  = port_e.inst;
            o_port_ex[i]             = port_e.ex;
            o_port_exccode[6*i +: 6] = port_e.exccode;
        end
    end

`ifdef CPU7_IFU_FQ_PERF_EN
    logic [31:0] perf_lines_q, perf_stall_q, perf_discard_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_lines_q   <= '0;
            perf_stall_q   <= '0;
            perf_discard_q <= '0;
        end else begin
            if (keep) perf_lines_q <= perf_lines_q + 32'd1;
            if (drop) perf_discard_q <= perf_discard_q + 32'd1;
            if (state_q == RUN && 32'(outst_q) < 32'(MAX_OUTST) && !space_ok)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_lines = perf_lines_q;
    assign perf_stall_full  = perf_stall_q;
    assign perf_discard     = perf_discard_q;
`else
    // Counters absent: no extra state in the default build.
`endif

endmodule
